// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit, register file and ALU:
// widths, opcode/ALU-op constants, FSM state type and instruction field positions.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 16;
  localparam int unsigned CPU_PC_W   = 8;
  localparam int unsigned CPU_REG_AW = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_XOR    = 3'd4;
  localparam logic [2:0] ALU_PASS_B = 3'd5;
  localparam logic [2:0] ALU_PASS_A = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned RD_MSB   = 11;
  localparam int unsigned RD_LSB   = 8;
  localparam int unsigned RS1_MSB  = 7;
  localparam int unsigned RS1_LSB  = 4;
  localparam int unsigned RS2_MSB  = 3;
  localparam int unsigned RS2_LSB  = 0;
  localparam int unsigned IMM8_MSB = 7;
  localparam int unsigned IMM4_MSB = 3;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decode: IR -> register addresses, ALU
// controls, zero-extended immediate and instruction-class flags.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [CPU_DATA_W-1:0] ir_i,
  output logic [CPU_REG_AW-1:0] rd_o,
  output logic [CPU_REG_AW-1:0] rs1_o,
  output logic [CPU_REG_AW-1:0] rs2_o,
  output logic [2:0]            alu_op_o,
  output logic [CPU_DATA_W-1:0] imm_o,
  output logic                  imm_sel_o,
  output logic                  writes_rd_o,
  output logic                  is_branch_o,
  output logic                  is_jmp_o,
  output logic                  is_halt_o,
  output logic                  illegal_o
);

  logic [3:0] opcode;

  always_comb begin
    opcode      = ir_i[OP_MSB:OP_LSB];
    rd_o        = ir_i[RD_MSB:RD_LSB];
    rs1_o       = ir_i[RS1_MSB:RS1_LSB];
    rs2_o       = ir_i[RS2_MSB:RS2_LSB];
    alu_op_o    = ALU_ADD;
    imm_o       = '0;
    imm_sel_o   = 1'b0;
    writes_rd_o = 1'b0;
    is_branch_o = 1'b0;
    is_jmp_o    = 1'b0;
    is_halt_o   = 1'b0;
    illegal_o   = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD: writes_rd_o = 1'b1;
      OP_SUB: begin
        alu_op_o    = ALU_SUB;
        writes_rd_o = 1'b1;
      end
      OP_AND: begin
        alu_op_o    = ALU_AND;
        writes_rd_o = 1'b1;
      end
      OP_OR: begin
        alu_op_o    = ALU_OR;
        writes_rd_o = 1'b1;
      end
      OP_XOR: begin
        alu_op_o    = ALU_XOR;
        writes_rd_o = 1'b1;
      end
      OP_ADDI: begin
        imm_o       = CPU_DATA_W'(ir_i[IMM4_MSB:0]);
        imm_sel_o   = 1'b1;
        writes_rd_o = 1'b1;
      end
      OP_LDI: begin
        alu_op_o    = ALU_PASS_B;
        imm_o       = CPU_DATA_W'(ir_i[IMM8_MSB:0]);
        imm_sel_o   = 1'b1;
        writes_rd_o = 1'b1;
      end
      OP_BEQZ: begin
        // The tested register sits in the rd field and goes out on read port 1.
        rs1_o       = ir_i[RD_MSB:RD_LSB];
        alu_op_o    = ALU_PASS_A;
        imm_o       = CPU_DATA_W'(ir_i[IMM8_MSB:0]);
        is_branch_o = 1'b1;
      end
      OP_JMP: begin
        imm_o    = CPU_DATA_W'(ir_i[IMM8_MSB:0]);
        is_jmp_o = 1'b1;
      end
      OP_HALT: is_halt_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control stage: fetches over req/ack into IR, decodes, and
// sequences FETCH/DECODE/EXECUTE/WRITEBACK in front of the register file.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned PC_W   = CPU_PC_W,
  parameter int unsigned REG_AW = CPU_REG_AW
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_imem_req,
  output logic [PC_W-1:0]   o_pc,
  input  logic              i_imem_ack,
  input  logic [DATA_W-1:0] i_imem_data,
  output logic [REG_AW-1:0] o_rf_read_add1,
  output logic [REG_AW-1:0] o_rf_read_add2,
  output logic [REG_AW-1:0] o_rf_write_add,
  output logic              o_rf_write_en,
  output logic [2:0]        o_alu_op,
  output logic              o_imm_sel,
  output logic [DATA_W-1:0] o_imm,
  input  logic              i_alu_zero,
  output logic              o_illegal,
  output logic              o_halted
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic writes_rd, is_branch, is_jmp, is_halt, illegal;

  instr_decoder u_dec (
    .ir_i        (ir_q),
    .rd_o        (o_rf_write_add),
    .rs1_o       (o_rf_read_add1),
    .rs2_o       (o_rf_read_add2),
    .alu_op_o    (o_alu_op),
    .imm_o       (o_imm),
    .imm_sel_o   (o_imm_sel),
    .writes_rd_o (writes_rd),
    .is_branch_o (is_branch),
    .is_jmp_o    (is_jmp),
    .is_halt_o   (is_halt),
    .illegal_o   (illegal)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (i_imem_ack) begin
          ir_d    = i_imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = is_halt ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: begin
        // PC already points past the branch; offset is sign-extended imm8.
        if (is_branch && i_alu_zero) pc_d = pc_q + PC_W'($signed(ir_q[IMM8_MSB:0]));
        if (is_jmp) pc_d = PC_W'(ir_q[IMM8_MSB:0]);
        state_d = writes_rd ? ST_WRITEBACK : ST_FETCH;
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Strobes come straight from the state register so they stay clean across the negedge write.
  assign o_imem_req    = (state_q == ST_FETCH);
  assign o_rf_write_en = (state_q == ST_WRITEBACK);
  assign o_illegal     = (state_q == ST_DECODE) && illegal;
  assign o_halted      = (state_q == ST_HALT);
  assign o_pc          = pc_q;

endmodule
